// File: rtl/dw_requant_out.sv
// Depthwise PE output stage: tracks tap windows, captures the final PE sum, then
// bias-adds, round-shifts, applies optional ReLU, saturates and buffers results in a FIFO.
module dw_requant_out #(
    parameter int unsigned KERNEL_TAPS = 9,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                tap_valid,
    input  logic                                tap_first,
    input  logic signed [ACC_WIDTH-1:0]         psum,
    input  logic signed [ACC_WIDTH-1:0]         bias,
    input  logic        [4:0]                   shift,
    input  logic                                relu_en,
    output logic signed [OUT_WIDTH-1:0]         out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic        [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                                overflow,
    output logic                                protocol_err
);

    localparam int unsigned CNT_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS + 1) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned S2W   = ACC_WIDTH + 2;

    localparam logic signed [S2W-1:0] SAT_MAX = S2W'((1 <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [S2W-1:0] SAT_MIN = S2W'(-(1 <<< (OUT_WIDTH - 1)));

    // ---------------- tap counter ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win_done;
    logic             proto_hit;
    logic             done_q;

    always_comb begin
        cnt_d     = cnt_q;
        win_done  = 1'b0;
        proto_hit = 1'b0;
        if (tap_valid) begin
            if (tap_first) begin
                if (KERNEL_TAPS == 1) begin
                    win_done = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end else if (cnt_q == '0) begin
                proto_hit = 1'b1;
            end else if (cnt_q == CNT_W'(KERNEL_TAPS - 1)) begin
                win_done = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            done_q       <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= win_done;
            if (proto_hit) protocol_err <= 1'b1;
        end
    end

    // ---------------- requant pipeline ----------------
    logic                     s1_valid_q, s2_valid_q;
    logic signed [ACC_WIDTH:0] s1_q;
    logic        [4:0]        shift1_q;
    logic                     relu1_q, relu2_q;
    logic signed [S2W-1:0]    s2_q;
    logic signed [S2W-1:0]    s1_ext, rnd, rsum, s2_calc;

    // PE sum register delay: the final sum is visible the cycle after the last tap.
    always_comb begin
        s1_ext = S2W'(s1_q);
        rnd    = '0;
        if (shift1_q != 5'd0) rnd = S2W'(1) <<< (shift1_q - 5'd1);
        rsum    = s1_ext + rnd;
        s2_calc = rsum >>> shift1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            shift1_q   <= '0;
            relu1_q    <= 1'b0;
            relu2_q    <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= done_q;
            s2_valid_q <= s1_valid_q;
            if (done_q) begin
                s1_q     <= (ACC_WIDTH + 1)'(psum) + (ACC_WIDTH + 1)'(bias);
                shift1_q <= shift;
                relu1_q  <= relu_en;
            end
            if (s1_valid_q) begin
                s2_q    <= s2_calc;
                relu2_q <= relu1_q;
            end
        end
    end

    // ---------------- relu + saturate ----------------
    logic signed [OUT_WIDTH-1:0] res;

    always_comb begin
        if (relu2_q && s2_q < 0)  res = '0;
        else if (s2_q > SAT_MAX)  res = SAT_MAX[OUT_WIDTH-1:0];
        else if (s2_q < SAT_MIN)  res = SAT_MIN[OUT_WIDTH-1:0];
        else                      res = s2_q[OUT_WIDTH-1:0];
    end

    // ---------------- output FIFO ----------------
    logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            rd_ptr_q, wr_ptr_q;
    logic [FCW-1:0]              count_q;
    logic                        push, pop, push_ok, full;

    assign out_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign out_data   = mem[rd_ptr_q];
    assign full       = (count_q == FCW'(FIFO_DEPTH));
    assign push       = s2_valid_q;
    assign pop        = out_valid && out_ready;
    assign push_ok    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr_q] <= res;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + FCW'(1);
                2'b01:   count_q <= count_q - FCW'(1);
                default: count_q <= count_q;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dw_requant_out.sv
// Self-checking bench for dw_requant_out: directed corner cases plus randomized windows
// checked against an arithmetic reference model and an expected-result queue.
module tb_dw_requant_out;

    localparam int K = 9;
    localparam int D = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              tap_valid, tap_first;
    logic signed [31:0] psum, bias;
    logic        [4:0] shift;
    logic              relu_en;
    logic signed [7:0] out_data;
    logic              out_valid, out_ready;
    logic        [2:0] fifo_count;
    logic              overflow, protocol_err;

    int checks   = 0;
    int failures = 0;
    logic signed [7:0] exp_q[$];

    dw_requant_out #(
        .KERNEL_TAPS(K), .ACC_WIDTH(32), .OUT_WIDTH(8), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset), .tap_valid(tap_valid), .tap_first(tap_first),
        .psum(psum), .bias(bias), .shift(shift), .relu_en(relu_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow(overflow), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    function automatic logic signed [7:0] ref_out(input logic signed [31:0] p,
                                                   input logic signed [31:0] b,
                                                   input int sh, input bit relu);
        longint s;
        s = longint'(p) + longint'(b);
        if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
        return s[7:0];
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Returns one cycle after the last tap; window values apply from the second tap on
    // so the previous window's final sum stays valid during a back-to-back first tap.
    task automatic send_window(input logic signed [31:0] p, input logic signed [31:0] b,
                               input int sh, input bit relu, input bit keep, input bit gaps);
        for (int i = 0; i < K; i++) begin
            tap_valid = 1'b1;
            tap_first = (i == 0);
            if (i > 0) begin
                psum = p; bias = b; shift = 5'(sh); relu_en = relu;
            end
            tick();
            if (gaps && i > 0 && i < K - 1 && $urandom_range(0, 3) == 0) begin
                tap_valid = 1'b0;
                tap_first = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
        end
        tap_valid = 1'b0;
        tap_first = 1'b0;
        if (keep) exp_q.push_back(ref_out(p, b, sh, relu));
    endtask

    task automatic drain(input bit rand_ready);
        int budget = 300;
        while (exp_q.size() > 0 && budget > 0) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) check("drain_data", out_data, exp_q.pop_front());
            tick();
            budget--;
        end
        out_ready = 1'b0;
        check("drain_timeout", exp_q.size(), 0);
        check("drain_empty", fifo_count, 0);
    endtask

    initial begin
        reset = 1'b1; tap_valid = 1'b0; tap_first = 1'b0; psum = '0; bias = '0;
        shift = '0; relu_en = 1'b0; out_ready = 1'b0;
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_perr", protocol_err, 0);

        // T1: saturation and latency
        send_window(1000, 24, 3, 0, 1, 0);
        tick(); tick();
        check("t1_valid_t3", out_valid, 0);
        tick();
        check("t1_valid_t4", out_valid, 1);
        check("t1_data", out_data, 127);
        check("t1_count", fifo_count, 1);
        drain(0);

        // T2: round half up on negative, then relu
        send_window(-300, -5, 2, 0, 1, 0);
        drain(0);
        send_window(-300, -5, 2, 1, 1, 0);
        drain(0);

        // T3: bias add does not wrap
        send_window(32'sh7fffffff, 32'sh7fffffff, 0, 0, 1, 0);
        drain(0);
        send_window(32'sh80000000, 32'sh80000000, 0, 0, 1, 0);
        drain(0);

        // T4: five back-to-back windows into a stalled FIFO
        do_reset();
        for (int w = 1; w <= 5; w++) send_window(10 * w, 0, 0, 0, (w <= 4), 0);
        tick(); tick();
        check("t4_ovf_before", overflow, 0);
        check("t4_count_before", fifo_count, 4);
        tick();
        check("t4_ovf_after", overflow, 1);
        check("t4_count_after", fifo_count, 4);
        check("t4_head", out_data, 10);
        drain(1);
        check("t4_ovf_sticky", overflow, 1);

        // T5: push and pop in the same cycle on a full FIFO
        do_reset();
        for (int w = 1; w <= 5; w++) send_window(10 * w, 0, 0, 0, (w <= 4), 0);
        tick(); tick();
        check("t5_count_full", fifo_count, 4);
        check("t5_head", out_data, exp_q[0]);
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(ref_out(50, 0, 0, 0));
        tick();
        out_ready = 1'b0;
        check("t5_ovf", overflow, 0);
        check("t5_count", fifo_count, 4);
        drain(0);

        // T6: orphan tap, then reset while a result is in flight
        do_reset();
        tap_valid = 1'b1; tap_first = 1'b0;
        tick();
        tap_valid = 1'b0;
        check("t6_perr", protocol_err, 1);
        repeat (6) tick();
        check("t6_no_out", out_valid, 0);
        send_window(5, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("t6_flush_valid", out_valid, 0);
            tick();
        end
        check("t6_perr_clr", protocol_err, 0);
        check("t6_ovf_clr", overflow, 0);
        check("t6_count_clr", fifo_count, 0);

        // Randomized bursts of windows, random gaps and random consumer stalls
        for (int r = 0; r < 15; r++) begin
            int n = $urandom_range(1, D);
            for (int w = 0; w < n; w++)
                send_window(32'($urandom), 32'($urandom), $urandom_range(0, 31),
                            1'($urandom_range(0, 1)), 1, 1);
            drain(1);
        end
        check("rand_ovf", overflow, 0);
        check("rand_perr", protocol_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
